// File: rtl/ahb_fabric_pkg.sv
// Shared AHB-Lite encodings, FSM states and select payload for the fabric.
package ahb_fabric_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned MAX_SLAVES = 16;
  localparam int unsigned IDX_W      = $clog2(MAX_SLAVES);
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERR1,
    ST_ERR2
  } err_state_t;

  // Data-phase owner captured at the end of each address phase.
  typedef struct packed {
    logic             valid;
    logic             dflt;
    logic [IDX_W-1:0] idx;
  } sel_t;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Two-cycle AHB ERROR responder for unmapped accesses and watchdog aborts.
module ahblite_default_slave
  import ahb_fabric_pkg::*;
(
  input  logic clk,
  input  logic RSTn,
  input  logic start,
  input  logic force_err,
  output logic busy_c,
  output logic ready_c,
  output logic resp_c
);

  err_state_t state;
  err_state_t state_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and response; ERR2 may chain straight into another error.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    ready_c   = 1'b1;
    resp_c    = HRESP_OKAY;
    case (state)
      ST_IDLE: begin
        if (start || force_err) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        busy_c    = 1'b1;
        ready_c   = 1'b0;
        resp_c    = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        busy_c    = 1'b1;
        resp_c    = HRESP_ERROR;
        state_nxt = start ? ST_ERR1 : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/ahblite_fabric.sv
// Single-master AHB-Lite interconnect: mask/base decode, registered return
// mux, built-in default slave. Optional stall watchdog: AHB_FABRIC_TIMEOUT_EN.
module ahblite_fabric
  import ahb_fabric_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES     = 5,
  parameter logic [32*NUM_SLAVES-1:0]     ADDR_BASE      = {32'h40020000, 32'h40010000,
                                                            32'h40000000, 32'h20000000,
                                                            32'h00000000},
  parameter logic [32*NUM_SLAVES-1:0]     ADDR_MASK      = {5{32'hFFFF0000}},
  parameter int unsigned                  TIMEOUT_CYCLES = 255
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic                    HMASTLOCK,
  input  logic [31:0]             HWDATA,
  output logic [31:0]             HRDATA,
  output logic                    HREADY,
  output logic                    HRESP,
  output logic [NUM_SLAVES-1:0]   HSEL_S,
  output logic                    HREADY_S,
  input  logic [32*NUM_SLAVES-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]   HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]   HRESP_S,
  output logic                    TIMEOUT_IRQ,
  output logic [3:0]              TIMEOUT_SLAVE
);

  logic             hit;
  logic [IDX_W-1:0] dec_idx;
  sel_t             sel_q;
  logic [31:0]      slv_rdata;
  logic             slv_ready;
  logic             slv_resp;
  logic             dflt_start;
  logic             force_err;
  logic             dflt_busy;
  logic             dflt_ready;
  logic             dflt_resp;

  // Master-side controls travel to the slaves on external wiring.
  logic unused_ok;
  assign unused_ok = ^{HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA};

  // Address decode; lowest matching index wins.
  always_comb begin
    HSEL_S  = '0;
    hit     = 1'b0;
    dec_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((HADDR & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32])) begin
        hit       = 1'b1;
        HSEL_S[i] = 1'b1;
        dec_idx   = IDX_W'(i);
      end
    end
  end

  // Data-phase select follows the address phase whenever the bus advances.
  always_ff @(posedge HCLK) begin
    if (!HRESETn)    sel_q <= '0;
    else if (HREADY) sel_q <= '{valid: 1'b1, dflt: !hit, idx: dec_idx};
  end

  // Pick the selected slave's return signals.
  always_comb begin
    slv_rdata = '0;
    slv_ready = 1'b1;
    slv_resp  = HRESP_OKAY;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q.idx == IDX_W'(i)) begin
        slv_rdata = HRDATA_S[32*i +: 32];
        slv_ready = HREADYOUT_S[i];
        slv_resp  = HRESP_S[i];
      end
    end
  end

  // An active error sequence overrides the slave; no owner means OKAY zero-wait.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    if (dflt_busy) begin
      HREADY = dflt_ready;
      HRESP  = dflt_resp;
    end else if (sel_q.valid && !sel_q.dflt) begin
      HRDATA = slv_rdata;
      HREADY = slv_ready;
      HRESP  = slv_resp;
    end
  end

  assign HREADY_S   = HREADY;
  assign dflt_start = !hit && trans_active(HTRANS) && HREADY;

  ahblite_default_slave u_dflt (
    .clk       (HCLK),
    .RSTn      (HRESETn),
    .start     (dflt_start),
    .force_err (force_err),
    .busy_c    (dflt_busy),
    .ready_c   (dflt_ready),
    .resp_c    (dflt_resp)
  );

`ifdef AHB_FABRIC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             stall;

  // A selected slave wait state that the fabric is not already overriding.
  assign stall     = !dflt_busy && sel_q.valid && !sel_q.dflt && !slv_ready;
  assign force_err = stall && (cnt_q == LIMIT);

  // Saturating stall counter, cleared on every completed transfer.
  always_ff @(posedge HCLK) begin
    if (!HRESETn)                cnt_q <= '0;
    else if (HREADY)             cnt_q <= '0;
    else if (stall && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Fire pulse lines up with ERR1; culprit index is sticky.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      TIMEOUT_IRQ   <= 1'b0;
      TIMEOUT_SLAVE <= '0;
    end else begin
      TIMEOUT_IRQ <= force_err;
      if (force_err) TIMEOUT_SLAVE <= 4'(sel_q.idx);
    end
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  assign force_err     = 1'b0;
  assign TIMEOUT_IRQ   = 1'b0;
  assign TIMEOUT_SLAVE = '0;
`endif

endmodule

// File: tb/tb_ahblite_fabric.sv
// Directed self-checking bench for ahblite_fabric (5 slaves, TIMEOUT_CYCLES=8).
`timescale 1ns/1ps
module tb_ahblite_fabric;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic          HMASTLOCK;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADY;
  logic          HRESP;
  logic [4:0]    HSEL_S;
  logic          HREADY_S;
  logic [159:0]  HRDATA_S;
  logic [4:0]    HREADYOUT_S;
  logic [4:0]    HRESP_S;
  logic          TIMEOUT_IRQ;
  logic [3:0]    TIMEOUT_SLAVE;

  int n_tests = 0;
  int n_fail  = 0;

  ahblite_fabric #(.TIMEOUT_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .HSEL_S(HSEL_S), .HREADY_S(HREADY_S), .HRDATA_S(HRDATA_S),
    .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .TIMEOUT_IRQ(TIMEOUT_IRQ),
    .TIMEOUT_SLAVE(TIMEOUT_SLAVE)
  );

  always #5 HCLK = ~HCLK;

  // Advance to 1 ns after the next rising edge.
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    HADDR = 32'h2000_0010; HTRANS = 2'b00;
    HRDATA_S[32 +: 32] = 32'h1234_5678;
    cyc(); cyc(); #1;
    n_tests++; if (HREADY !== 1'b1) begin n_fail++; $display("FAIL reset_hready got %b want 1", HREADY); end
    n_tests++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_hresp got %b want 0", HRESP); end
    n_tests++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got %h want 0", HRDATA); end
    n_tests++; if (TIMEOUT_IRQ !== 1'b0 || TIMEOUT_SLAVE !== 4'd0) begin n_fail++; $display("FAIL reset_timeout got %b/%0d want 0/0", TIMEOUT_IRQ, TIMEOUT_SLAVE); end
    n_tests++; if (HSEL_S !== 5'b00010) begin n_fail++; $display("FAIL reset_hsel got %b want 00010", HSEL_S); end
    cyc(); HRESETn = 1'b1; HADDR = 32'h0; #1;
    cyc();
  endtask

  task automatic test_decode();
    logic [31:0] addrs [6];
    logic [4:0]  exps  [6];
    addrs = '{32'h0000_1234, 32'h4000_0000, 32'h4001_FFFC, 32'h4002_0000, 32'h6000_0000, 32'h4003_0000};
    exps  = '{5'b00001, 5'b00100, 5'b01000, 5'b10000, 5'b00000, 5'b00000};
    for (int i = 0; i < 6; i++) begin
      HADDR = addrs[i]; HTRANS = 2'b00; #1;
      n_tests++; if (HSEL_S !== exps[i]) begin n_fail++; $display("FAIL decode_%0d addr %h got %b want %b", i, addrs[i], HSEL_S, exps[i]); end
    end
    HADDR = 32'h0;
  endtask

  task automatic test_read();
    cyc(); HADDR = 32'h2000_0010; HTRANS = 2'b10; HWRITE = 1'b0;
    HRDATA_S[32 +: 32] = 32'hCAFE_F00D; #1;
    n_tests++; if (HSEL_S !== 5'b00010) begin n_fail++; $display("FAIL read_hsel got %b want 00010", HSEL_S); end
    cyc(); HADDR = 32'h0; HTRANS = 2'b00; #1;
    n_tests++; if (HRDATA !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL read_data got %h want cafef00d", HRDATA); end
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin n_fail++; $display("FAIL read_resp got %b/%b want 1/0", HREADY, HRESP); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [5];
    int          slot  [5];
    addrs = '{32'h0000_0100, 32'h4000_0000, 32'h4001_0000, 32'h4002_0000, 32'h2000_0000};
    slot  = '{0, 2, 3, 4, 1};
    for (int i = 0; i < 5; i++) HRDATA_S[32*i +: 32] = 32'hA000_0000 | 32'(i);
    for (int j = 0; j <= 5; j++) begin
      cyc();
      HADDR  = (j < 5) ? addrs[j] : 32'h0;
      HTRANS = (j < 5) ? 2'b10 : 2'b00;
      #1;
      if (j > 0) begin
        n_tests++; if (HRDATA !== (32'hA000_0000 | 32'(slot[j-1]))) begin n_fail++; $display("FAIL b2b_data_%0d got %h want %h", j, HRDATA, 32'hA000_0000 | 32'(slot[j-1])); end
      end
    end
  endtask

  task automatic test_unmapped();
    cyc(); HADDR = 32'h6000_0000; HTRANS = 2'b10; HWRITE = 1'b1; #1;
    n_tests++; if (HSEL_S !== 5'b00000) begin n_fail++; $display("FAIL unmapped_hsel got %b want 00000", HSEL_S); end
    cyc(); HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0; #1;
    n_tests++; if (HREADY !== 1'b0 || HRESP !== 1'b1 || HRDATA !== 32'h0) begin n_fail++; $display("FAIL unmapped_err1 got %b/%b/%h want 0/1/0", HREADY, HRESP, HRDATA); end
    cyc(); #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin n_fail++; $display("FAIL unmapped_err2 got %b/%b want 1/1", HREADY, HRESP); end
    cyc(); #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin n_fail++; $display("FAIL unmapped_after got %b/%b want 1/0", HREADY, HRESP); end
  endtask

  task automatic test_err_back_to_back();
    cyc(); HADDR = 32'h6000_0000; HTRANS = 2'b10; #1;
    cyc(); #1;
    n_tests++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin n_fail++; $display("FAIL b2berr_err1a got %b/%b want 0/1", HREADY, HRESP); end
    cyc(); #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin n_fail++; $display("FAIL b2berr_err2a got %b/%b want 1/1", HREADY, HRESP); end
    cyc(); HTRANS = 2'b00; #1;
    n_tests++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin n_fail++; $display("FAIL b2berr_err1b got %b/%b want 0/1", HREADY, HRESP); end
    cyc(); #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin n_fail++; $display("FAIL b2berr_err2b got %b/%b want 1/1", HREADY, HRESP); end
    cyc(); #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin n_fail++; $display("FAIL b2berr_idle_okay got %b/%b want 1/0", HREADY, HRESP); end
    cyc(); HADDR = 32'h0; #1;
  endtask

  task automatic test_stall();
    cyc(); HADDR = 32'h4000_0000; HTRANS = 2'b10; #1;
    cyc(); HADDR = 32'h0; HTRANS = 2'b00; HREADYOUT_S[2] = 1'b0; HRDATA_S[64 +: 32] = 32'h2222_3333; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin cyc(); #1; end
      n_tests++; if (HREADY !== 1'b0 || HRESP !== 1'b0 || HREADY_S !== 1'b0) begin n_fail++; $display("FAIL stall_wait_%0d got %b/%b/%b want 0/0/0", i, HREADY, HRESP, HREADY_S); end
    end
    cyc(); HREADYOUT_S[2] = 1'b1; #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h2222_3333) begin n_fail++; $display("FAIL stall_done got %b/%b/%h want 1/0/22223333", HREADY, HRESP, HRDATA); end
    cyc(); #1;
  endtask

`ifdef AHB_FABRIC_TIMEOUT_EN
  task automatic test_timeout();
    cyc(); HADDR = 32'h4002_0000; HTRANS = 2'b10; #1;
    cyc(); HADDR = 32'h0; HTRANS = 2'b00; HREADYOUT_S[4] = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin cyc(); #1; end
      n_tests++; if (HREADY !== 1'b0 || HRESP !== 1'b0 || TIMEOUT_IRQ !== 1'b0) begin n_fail++; $display("FAIL timeout_stall_%0d got %b/%b/%b want 0/0/0", i, HREADY, HRESP, TIMEOUT_IRQ); end
    end
    cyc(); #1;
    n_tests++; if (HREADY !== 1'b0 || HRESP !== 1'b1 || TIMEOUT_IRQ !== 1'b1) begin n_fail++; $display("FAIL timeout_err1 got %b/%b/%b want 0/1/1", HREADY, HRESP, TIMEOUT_IRQ); end
    n_tests++; if (TIMEOUT_SLAVE !== 4'd4) begin n_fail++; $display("FAIL timeout_slave got %0d want 4", TIMEOUT_SLAVE); end
    cyc(); #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b1 || TIMEOUT_IRQ !== 1'b0 || HREADY_S !== 1'b1) begin n_fail++; $display("FAIL timeout_err2 got %b/%b/%b/%b want 1/1/0/1", HREADY, HRESP, TIMEOUT_IRQ, HREADY_S); end
    cyc(); HREADYOUT_S[4] = 1'b1; #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || TIMEOUT_SLAVE !== 4'd4) begin n_fail++; $display("FAIL timeout_after got %b/%b/%0d want 1/0/4", HREADY, HRESP, TIMEOUT_SLAVE); end
  endtask

  task automatic test_timeout_race();
    cyc(); HADDR = 32'h4000_0000; HTRANS = 2'b10; #1;
    cyc(); HADDR = 32'h0; HTRANS = 2'b00; HREADYOUT_S[2] = 1'b0; #1;
    for (int i = 1; i < 7; i++) begin cyc(); #1; end
    cyc(); HREADYOUT_S[2] = 1'b1; #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin n_fail++; $display("FAIL race_done got %b/%b want 1/0", HREADY, HRESP); end
    cyc(); #1;
    n_tests++; if (HRESP !== 1'b0 || TIMEOUT_IRQ !== 1'b0) begin n_fail++; $display("FAIL race_noirq got %b/%b want 0/0", HRESP, TIMEOUT_IRQ); end
  endtask
`else
  task automatic test_no_timeout();
    cyc(); HADDR = 32'h4002_0000; HTRANS = 2'b10; #1;
    cyc(); HADDR = 32'h0; HTRANS = 2'b00; HREADYOUT_S[4] = 1'b0; #1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin cyc(); #1; end
      n_tests++; if (HREADY !== 1'b0 || HRESP !== 1'b0 || TIMEOUT_IRQ !== 1'b0) begin n_fail++; $display("FAIL notimeout_stall_%0d got %b/%b/%b want 0/0/0", i, HREADY, HRESP, TIMEOUT_IRQ); end
    end
    cyc(); HREADYOUT_S[4] = 1'b1; #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || TIMEOUT_SLAVE !== 4'd0) begin n_fail++; $display("FAIL notimeout_done got %b/%b/%0d want 1/0/0", HREADY, HRESP, TIMEOUT_SLAVE); end
  endtask
`endif

  task automatic test_reset_mid();
    cyc(); HADDR = 32'h6000_0000; HTRANS = 2'b10; #1;
    cyc(); HADDR = 32'h0; HTRANS = 2'b00; #1;
    n_tests++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin n_fail++; $display("FAIL rstmid_err1 got %b/%b want 0/1", HREADY, HRESP); end
    HRESETn = 1'b0;
    cyc(); #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin n_fail++; $display("FAIL rstmid_abort got %b/%b/%h want 1/0/0", HREADY, HRESP, HRDATA); end
    HRESETn = 1'b1;
    cyc(); #1;
    n_tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got %b/%b want 1/0", HREADY, HRESP); end
  endtask

  initial begin
    HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010; HBURST = 3'b000;
    HPROT = 4'b0011; HMASTLOCK = 1'b0; HWDATA = '0; HRDATA_S = '0;
    HREADYOUT_S = 5'b11111; HRESP_S = 5'b00000; HRESETn = 1'b0;
    test_reset();
    test_decode();
    test_read();
    test_back_to_back();
    test_unmapped();
    test_err_back_to_back();
    test_stall();
`ifdef AHB_FABRIC_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit reached at %0t, want completion earlier", $time);
    $fatal(1, "time limit");
  end

endmodule
